// File: rtl/example_01_driver.sv
// example_01_driver
// Initiator-side sequencer for the A/B/C/D -> Q handshake FSM. When a start
// pulse arrives it walks the target through Q = 0 -> 1 -> 2 -> 3 -> 4 -> 0.
// Each step waits for the target's Q to show the expected value, then moves on.
// At the end it reports either a one-cycle done pulse or a sticky error.
//
// Ports:
//   clk        rising-edge clock, shared with the target FSM
//   rst        asynchronous, active-high reset
//   start      single-cycle request to run one full sequence
//   Q[2:0]     target FSM state code (acknowledgement feedback)
//   A, B, C    single-bit stimulus to the target
//   D[3:0]     4-bit stimulus to the target
//   busy       high while a sequence is in progress
//   done       one-cycle pulse on successful completion
//   err        sticky error flag
//   errStep    step at which the error occurred (0 = bad Q at start)
//   errTimeout 1 = step timed out, 0 = illegal Q value seen
module example_01_driver #(
  parameter  int TIMEOUT = 16,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] Q,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [3:0] D,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] errStep,
  output logic       errTimeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ST_A   = 3'd1,
    ST_D1  = 3'd2,
    ST_ABC = 3'd3,
    ST_DF  = 3'd4,
    ST_RET = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          done_next;
  logic          err_next;
  logic [2:0]    err_step_next;
  logic          err_timeout_next;

  // Per-step decode: step number, Q we are waiting for, Q the target should
  // still show until it acknowledges, and where to go on acknowledgement.
  logic [2:0] step;
  logic [2:0] exp_q;
  logic [2:0] prev_q;
  state_t     adv_state;

  always_comb begin
    step      = 3'd0;
    exp_q     = 3'd0;
    prev_q    = 3'd0;
    adv_state = IDLE;
    case (state_reg)
      ST_A:   begin step = 3'd1; exp_q = 3'd1; prev_q = 3'd0; adv_state = ST_D1;  end
      ST_D1:  begin step = 3'd2; exp_q = 3'd2; prev_q = 3'd1; adv_state = ST_ABC; end
      ST_ABC: begin step = 3'd3; exp_q = 3'd3; prev_q = 3'd2; adv_state = ST_DF;  end
      ST_DF:  begin step = 3'd4; exp_q = 3'd4; prev_q = 3'd3; adv_state = ST_RET; end
      ST_RET: begin step = 3'd5; exp_q = 3'd0; prev_q = 3'd4; adv_state = IDLE;   end
      default: ;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    done_next        = 1'b0;
    err_next         = err;
    err_step_next    = errStep;
    err_timeout_next = errTimeout;

    case (state_reg)
      // A start in ERR clears the error and is then handled exactly as it
      // would be from IDLE, all in the same cycle.
      IDLE, ERR: begin
        timer_next = '0;
        if (start) begin
          err_step_next    = 3'd0;
          err_timeout_next = 1'b0;
          if (Q == 3'd0) begin
            state_next = ST_A;
            err_next   = 1'b0;
          end else begin
            state_next = ERR;
            err_next   = 1'b1;
          end
        end
      end

      // Drive steps. The match is checked first, so an acknowledgement that
      // lands on the last timer count still advances.
      ST_A, ST_D1, ST_ABC, ST_DF, ST_RET: begin
        if (Q == exp_q) begin
          state_next = adv_state;
          timer_next = '0;
          done_next  = (state_reg == ST_RET);
        end else if (Q != prev_q) begin
          state_next       = ERR;
          timer_next       = '0;
          err_next         = 1'b1;
          err_step_next    = step;
          err_timeout_next = 1'b0;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          state_next       = ERR;
          timer_next       = '0;
          err_next         = 1'b1;
          err_step_next    = step;
          err_timeout_next = 1'b1;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      errStep    <= 3'd0;
      errTimeout <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      done       <= done_next;
      err        <= err_next;
      errStep    <= err_step_next;
      errTimeout <= err_timeout_next;
    end
  end

  // Stimulus and busy are decoded straight from the state register.
  assign A    = (state_reg == ST_A) || (state_reg == ST_ABC);
  assign B    = (state_reg == ST_ABC);
  assign C    = (state_reg == ST_ABC);
  assign D    = (state_reg == ST_D1) ? 4'b0001 :
                (state_reg == ST_DF) ? 4'b1111 : 4'b0000;
  assign busy = (state_reg == ST_A)   || (state_reg == ST_D1) ||
                (state_reg == ST_ABC) || (state_reg == ST_DF) ||
                (state_reg == ST_RET);

endmodule

// File: doc/example_01_driver.md
Name: example_01_driver

Overview:
- Initiator-side sequencer for the five-state A/B/C/D → Q handshake FSM (Q steps 0→1→2→3→4→0).
- On a start pulse, drives A, B, C and D through the full legal stimulus sequence.
- Uses the target's Q output as acknowledgement for each step and reports done or error.
- Sits beside the target FSM as a bring-up and self-test master; its outputs connect directly to the target's A/B/C/D inputs.

Parameters:
- TIMEOUT, 16, maximum cycles spent in any drive step waiting for the expected Q before flagging an error (legal range 2..255).
- TW, $clog2(TIMEOUT+1), width of the step timer (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock, shared with the target FSM
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to run one full sequence
- Q  input  3  target FSM state code, feedback
- A  output  1  stimulus to target
- B  output  1  stimulus to target
- C  output  1  stimulus to target
- D  output  4  stimulus to target
- busy  output  1  high while a sequence is in progress
- done  output  1  one-cycle pulse on successful completion
- err  output  1  sticky error flag
- errStep  output  3  step at which the error occurred
- errTimeout  output  1  1 = timeout, 0 = illegal Q value

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, timer=0. Outputs A=B=C=0, D=4'b0000, busy=0, done=0, err=0, errStep=0, errTimeout=0. Reset takes effect immediately, including mid-sequence.
- A/B/C/D and busy are Moore-decoded from the state register.
- done, err, errStep and errTimeout are registered.

States and stimulus (all stimulus not listed is 0):
- IDLE: no stimulus.
- ST_A (step 1): A=1; expect Q=1; previous Q=0.
- ST_D1 (step 2): D=4'b0001; expect Q=2; previous Q=1.
- ST_ABC (step 3): A=B=C=1; expect Q=3; previous Q=2.
- ST_DF (step 4): D=4'b1111; expect Q=4; previous Q=3.
- ST_RET (step 5): no stimulus; expect Q=0; previous Q=4.
- ERR: no stimulus.

Transitions:
- IDLE:
  - start=1 and Q=0 → ST_A.
  - start=1 and Q≠0 → ERR with errStep=0, errTimeout=0.
- Drive step, at each clock edge, in priority order:
  1. Q==expected → next step. Timer clears. ST_RET → IDLE with done=1 for exactly one cycle.
  2. Q not in {previous, expected} → ERR with errStep=step, errTimeout=0.
  3. timer==TIMEOUT-1 → ERR with errStep=step, errTimeout=1.
  4. Otherwise timer increments.
- A match on the same edge as the timeout wins; no error is raised.
- ERR:
  - err=1, errStep and errTimeout hold.
  - start=1 clears err/errStep/errTimeout and applies the IDLE start rules in the same cycle.
  - Only start or rst leave ERR.
- busy=1 in ST_A..ST_RET; 0 in IDLE and ERR.
- start is ignored while busy=1.
- Nominal latency against a registered-state target: 2 cycles per step.
  - Start seen at edge 0; ST_A from edge 1; Q=1 visible after edge 2; ST_D1 at edge 3; and so on.
  - done asserts 11 cycles after the start edge.
- Timer is TW bits wide, zeroed on every state entry, and never wraps.

Test Plan:
- Reset, then start pulse with a correct target FSM → A, then D=0001, then A=B=C=1, then D=1111, then idle. done pulses once at cycle 11; err=0; busy high cycles 1..10.
- Target held with Q=1 stuck, TIMEOUT=16 → in ST_D1, err=1 after 16 cycles, errStep=2, errTimeout=1, all stimulus 0, busy=0.
- Q jumps 2→4 during ST_ABC → err=1 next edge, errStep=3, errTimeout=0.
- start while Q=3 in IDLE → err=1, errStep=0. A following start with Q=0 clears err and completes normally.
- rst asserted asynchronously mid-ST_DF → all outputs 0 immediately, state IDLE. No done pulse after release.
- start re-pulsed during busy → ignored; exactly one done pulse. Match and timeout on the same cycle → advance, no err.
